// File: rtl/fft4_stream_ctrl.sv
// Four-sample streaming FFT sequencer: load 4 samples, compute in one cycle, unload 4 bins.
// Optional FFT4_CTRL_PRESCALE_EN: samples are arithmetic-shifted right by 2 on capture.
module fft4point #(
    parameter int W = 16
) (
    input  logic [3:0][W-1:0] x_re_i,
    input  logic [3:0][W-1:0] x_im_i,
    output logic [3:0][W-1:0] y_re_o,
    output logic [3:0][W-1:0] y_im_o
);
    logic [W-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;

    // Radix-2 split: even pair (a,b), odd pair (c,d); -j twiddle on d swaps re/im.
    always_comb begin
        a_re = x_re_i[0] + x_re_i[2];
        a_im = x_im_i[0] + x_im_i[2];
        b_re = x_re_i[0] - x_re_i[2];
        b_im = x_im_i[0] - x_im_i[2];
        c_re = x_re_i[1] + x_re_i[3];
        c_im = x_im_i[1] + x_im_i[3];
        d_re = x_re_i[1] - x_re_i[3];
        d_im = x_im_i[1] - x_im_i[3];
        y_re_o[0] = a_re + c_re;
        y_im_o[0] = a_im + c_im;
        y_re_o[1] = b_re + d_im;
        y_im_o[1] = b_im - d_re;
        y_re_o[2] = a_re - c_re;
        y_im_o[2] = a_im - c_im;
        y_re_o[3] = b_re - d_im;
        y_im_o[3] = b_im + d_re;
    end
endmodule

module fft4_stream_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         frame_err
);
    typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;

    state_t             state_q, state_d;
    logic [1:0]         icnt_q, icnt_d;
    logic [1:0]         ocnt_q, ocnt_d;
    logic               ferr_q, ferr_d;
    logic [3:0][W-1:0]  x_re_q, x_im_q;
    logic [3:0][W-1:0]  y_re_q, y_im_q;
    logic [3:0][W-1:0]  f_re, f_im;
    logic [W-1:0]       cap_re, cap_im;
    logic               in_beat;

`ifdef FFT4_CTRL_PRESCALE_EN
    assign cap_re = $signed(in_re) >>> 2;
    assign cap_im = $signed(in_im) >>> 2;
`else
    assign cap_re = in_re;
    assign cap_im = in_im;
`endif

    fft4point #(.W(W)) u_fft (
        .x_re_i (x_re_q),
        .x_im_i (x_im_q),
        .y_re_o (f_re),
        .y_im_o (f_im)
    );

    assign in_beat = in_valid && (state_q == LOAD);

    always_comb begin
        state_d   = state_q;
        icnt_d    = icnt_q;
        ocnt_d    = ocnt_q;
        ferr_d    = 1'b0;
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == UNLOAD);
        out_re    = '0;
        out_im    = '0;
        out_idx   = ocnt_q;
        out_last  = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_beat) begin
                    // A misplaced in_last drops the partial frame; the beat is still consumed.
                    if (in_last != (icnt_q == 2'd3)) begin
                        ferr_d = 1'b1;
                        icnt_d = 2'd0;
                    end else if (icnt_q == 2'd3) begin
                        icnt_d  = 2'd0;
                        state_d = CALC;
                    end else begin
                        icnt_d = icnt_q + 2'd1;
                    end
                end
            end
            CALC: state_d = UNLOAD;
            UNLOAD: begin
                out_re   = y_re_q[ocnt_q];
                out_im   = y_im_q[ocnt_q];
                out_last = (ocnt_q == 2'd3);
                if (out_ready) begin
                    ocnt_d = ocnt_q + 2'd1;
                    if (ocnt_q == 2'd3) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign frame_err = ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            ferr_q  <= 1'b0;
            x_re_q  <= '0;
            x_im_q  <= '0;
            y_re_q  <= '0;
            y_im_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            ocnt_q  <= ocnt_d;
            ferr_q  <= ferr_d;
            if (in_beat) begin
                x_re_q[icnt_q] <= cap_re;
                x_im_q[icnt_q] <= cap_im;
            end
            if (state_q == CALC) begin
                y_re_q <= f_re;
                y_im_q <= f_im;
            end
        end
    end
endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Randomized self-checking bench for fft4_stream_ctrl against a plain-arithmetic DFT model.
module tb_fft4_stream_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         frame_err;

    fft4_stream_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [1:0]   idx;
    } bin_t;

    bin_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_in = 0;
    int   fr[4];
    int   fi[4];
    bit   rdy_manual = 1'b1;
    int   rdy_pct = 100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pre(input int v);
`ifdef FFT4_CTRL_PRESCALE_EN
        return v >>> 2;
`else
        return v;
`endif
    endfunction

    // X[k] = sum x[n] * e^(-j*2*pi*n*k/4), twiddles tabulated as exact integers.
    function automatic void push_bins();
        int tr[4] = '{1, 0, -1, 0};
        int ti[4] = '{0, -1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            int sr, si, m;
            bin_t b;
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                m  = (n * k) % 4;
                sr += fr[n] * tr[m] - fi[n] * ti[m];
                si += fr[n] * ti[m] + fi[n] * tr[m];
            end
            b.re  = sr[W-1:0];
            b.im  = si[W-1:0];
            b.idx = k[1:0];
            exp_q.push_back(b);
        end
    endfunction

    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input int re, input int im, input bit last);
        bit exp_err;
        int t;
        in_re    = re[W-1:0];
        in_im    = im[W-1:0];
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_err = (last != (n_in == 3));
        if (exp_err) begin
            n_in = 0;
        end else begin
            fr[n_in] = pre(re);
            fi[n_in] = pre(im);
            if (n_in == 3) begin
                push_bins();
                n_in = 0;
            end else begin
                n_in++;
            end
        end
        chk("frame_err", frame_err, exp_err);
    endtask

    task automatic send_frame(input int r0, i0, r1, i1, r2, i2, r3, i3);
        send(r0, i0, 1'b0);
        send(r1, i1, 1'b0);
        send(r2, i2, 1'b0);
        send(r3, i3, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rdy_manual) out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Output monitor: scoreboard on accepted bins, stability while stalled.
    bit           hold_prev = 1'b0;
    logic [W-1:0] p_re, p_im;
    logic [1:0]   p_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_re", out_re, p_re);
                chk("hold_im", out_im, p_im);
                chk("hold_idx", out_idx, p_idx);
            end
            if (out_valid) chk("in_ready_unload", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_bin", 32'd1, 32'd0);
                end else begin
                    bin_t e;
                    e = exp_q.pop_front();
                    chk("bin_re", out_re, e.re);
                    chk("bin_im", out_im, e.im);
                    chk("bin_idx", out_idx, e.idx);
                    chk("bin_last", out_last, e.idx == 2'd3);
                end
            end
            hold_prev = out_valid && !out_ready;
            p_re  = out_re;
            p_im  = out_im;
            p_idx = out_idx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_re", out_re, '0);
        chk("rst_out_im", out_im, '0);
        chk("rst_out_idx", out_idx, 2'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Real ramp with two-cycle output latency
        rdy_manual = 1'b1;
        out_ready  = 1'b1;
`ifdef FFT4_CTRL_PRESCALE_EN
        send_frame(4, 0, 8, 0, 12, 0, 16, 0);
`else
        send_frame(1, 0, 2, 0, 3, 0, 4, 0);
`endif
        chk("lat_calc_valid", out_valid, 1'b0);
        chk("lat_calc_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("lat_first_valid", out_valid, 1'b1);
        chk("lat_first_idx", out_idx, 2'd0);
        drain();

`ifdef FFT4_CTRL_PRESCALE_EN
        send_frame(-3, 0, 0, 0, 0, 0, 0, 0);
`else
        send_frame(10, 5, 0, -5, -3, 2, 7, -3);
`endif
        drain();

        // Backpressure at bin 1 for five cycles
        send_frame(1, 0, 2, 0, 3, 0, 4, 0);
        begin
            int t;
            t = 0;
            while (!(out_valid && out_idx == 2'd1) && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            chk("bp_reach_bin1", out_idx, 2'd1);
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_still_bin1", out_idx, 2'd1);
        out_ready = 1'b1;
        drain();

        // Framing error on 2nd sample, then a good frame
        send(7, 7, 1'b0);
        send(8, 8, 1'b1);
        send_frame(1, 0, 2, 0, 3, 0, 4, 0);
        drain();

        // Asynchronous reset during bin 2 of the unload
        send_frame(5, 1, -6, 2, 7, -3, 8, 4);
        begin
            int t;
            t = 0;
            while (!(out_valid && out_idx == 2'd2) && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            chk("rst_reach_bin2", out_idx, 2'd2);
        end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_in = 0;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_re", out_re, '0);
        chk("arst_out_im", out_im, '0);
        chk("arst_out_idx", out_idx, 2'd0);
        chk("arst_out_last", out_last, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_rst_valid", out_valid, 1'b0);
            chk("post_rst_ready", in_ready, 1'b1);
        end

        // Randomized frames with random backpressure and occasional framing errors
        rdy_manual = 1'b0;
        rdy_pct    = 60;
        for (int s = 0; s < 120; s++) begin
            logic [W-1:0] r, i;
            bit last;
            r = W'($urandom);
            i = W'($urandom);
            last = (n_in == 3);
            if ($urandom_range(0, 19) == 0) last = !last;
            send(int'($signed(r)), int'($signed(i)), last);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("end_out_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
